hilo_md_unit: RTL and testbench

Multiply/divide unit for the EX stage: accepts mult/multu/div/divu/mthi/mtlo from the pipeline, runs multi-cycle operations, and owns the HI and LO architectural registers. It is the writer side of the HI/LO read path: `hi`/`lo` feed the mfhi/mflo select mux downstream. `busy` and `start` together drive the hazard unit's stall for any following HI/LO instruction.

---
 rtl/hilo_md_pkg.sv | 26 ++
 rtl/hilo_md_unit.sv | 121 ++++++++++++
 tb/tb_hilo_md_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hilo_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hilo_md_pkg;

    // md_op encodings as presented by the decode/EX stage
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Default occupancy of the iterative units, in cycles
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/hilo_md_unit.sv
// Multiply/divide unit owning HI/LO; mult/div results land after MULT_CYCLES/DIV_CYCLES.
// Latency: mthi/mtlo 1 edge; mult/div N edges from the accepting edge, busy high throughout.
// Backpressure: none accepted; starts while busy are dropped, the hazard unit must stall.
module hilo_md_unit
    import hilo_md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi_q, res_lo_q;
    logic        res_wr_q;

    logic        is_mul, is_div, accept;
    logic        last_cycle;
    logic [63:0] prod;
    logic [31:0] num, den, den_safe, uq, ur;
    logic [31:0] quo, rem;
    logic        sgn_div;

    assign is_mul     = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div     = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign accept     = (state_q == IDLE) && start && (is_mul || is_div);
    assign last_cycle = (state_q == RUN) && (cnt_q == CW'(1));

    // Product and quotient/remainder from the live operands; only latched on accept.
    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        prod    = '0;
        sgn_div = (md_op == MD_DIV);
        if (md_op == MD_MULT)
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            prod = {32'b0, a} * {32'b0, b};
        num      = (sgn_div && a[31]) ? (~a + 32'd1) : a;
        den      = (sgn_div && b[31]) ? (~b + 32'd1) : b;
        den_safe = (den == 32'd0) ? 32'd1 : den;
        uq       = num / den_safe;
        ur       = num % den_safe;
        quo      = (sgn_div && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
        rem      = (sgn_div && a[31]) ? (~ur + 32'd1) : ur;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: leave IDLE on an accepted mult/div, return when the count expires
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_cycle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latency counter and result latch; loaded only on an accepted mult/div
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            if (is_mul) begin
                res_hi_q <= prod[63:32];
                res_lo_q <= prod[31:0];
                res_wr_q <= 1'b1;
            end else begin
                res_hi_q <= rem;
                res_lo_q <= quo;
                res_wr_q <= (b != 32'd0);
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // HI/LO architectural registers: written by mthi/mtlo in IDLE or by a completing op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (last_cycle) begin
            if (res_wr_q) begin
                hi_q <= res_hi_q;
                lo_q <= res_lo_q;
            end
        end else if ((state_q == IDLE) && start) begin
            if (md_op == MD_MTHI) hi_q <= a;
            if (md_op == MD_MTLO) lo_q <= a;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
module tb_hilo_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Architectural effect of one operation, from plain integer arithmetic
    task automatic model(input int op, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] h, inout logic [31:0] l);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            1: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
            2: begin p = 64'(x) * 64'(y); h = p[63:32]; l = p[31:0]; end
            3: if (y != 0) begin
                q = sx / sy; r = sx % sy;
                l = q[31:0]; h = r[31:0];
            end
            4: if (y != 0) begin l = x / y; h = x % y; end
            5: h = x;
            6: l = x;
            default: ;
        endcase
    endtask

    // Drive one op at the current negedge and check the whole visible timeline.
    // inj drops an illegal start into the busy window, which must be ignored.
    task automatic do_op(input int op, input logic [31:0] x, input logic [31:0] y,
                         input bit inj, input string tag);
        int n;
        start = 1'b1; md_op = 3'(op); a = x; b = y;
        n = (op == 1 || op == 2) ? MC : ((op == 3 || op == 4) ? DC : 0);
        @(negedge clk);
        start = 1'b0; md_op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        if (n == 0) begin
            model(op, x, y, exp_hi, exp_lo);
            chk({tag, ".busy"}, 32'(busy), 32'd0);
            chk({tag, ".hi"}, hi, exp_hi);
            chk({tag, ".lo"}, lo, exp_lo);
        end else begin
            for (int k = 0; k < n; k++) begin
                chk($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
                chk($sformatf("%s.hold_hi%0d", tag, k), hi, exp_hi);
                chk($sformatf("%s.hold_lo%0d", tag, k), lo, exp_lo);
                start = inj && (k == 1);
                if (start) begin md_op = 3'd5; a = 32'hDEAD_BEEF; end
                @(negedge clk);
                start = 1'b0;
            end
            model(op, x, y, exp_hi, exp_lo);
            chk({tag, ".done_busy"}, 32'(busy), 32'd0);
            chk({tag, ".hi"}, hi, exp_hi);
            chk({tag, ".lo"}, lo, exp_lo);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mult_m1");
        do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        do_op(5, 32'h11, 32'd0, 1'b0, "mthi11");
        do_op(6, 32'h22, 32'd0, 1'b0, "mtlo22");
        do_op(4, 32'd7, 32'd0, 1'b0, "divu_by0");
        do_op(3, 32'h1234, 32'd0, 1'b0, "div_by0");
        do_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(1, 32'h0001_0003, 32'hFFFF_0007, 1'b1, "mult_ignore");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_ignore.busy%0d", k), 32'(busy), 32'd0);
            @(negedge clk);
        end
        do_op(5, 32'h1234, 32'd0, 1'b0, "mthi1234");
        do_op(6, 32'h5678, 32'd0, 1'b0, "mtlo5678");
        do_op(4, 32'hFFFF_FFFF, 32'd10, 1'b0, "divu_big");
        do_op(0, 32'hAAAA_AAAA, 32'd1, 1'b0, "none");
        do_op(7, 32'hBBBB_BBBB, 32'd1, 1'b0, "op7");

        // Randomized ops, back-to-back
        for (int i = 0; i < 30; i++) begin
            int op;
            logic [31:0] x, y;
            op = $urandom_range(0, 7);
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
            do_op(op, x, y, ($urandom_range(0, 1) == 1), $sformatf("rnd%0d_op%0d", i, op));
        end

        // Reset mid-operation: aborts the mult, no write after release
        do_op(5, 32'h5555_0000, 32'd0, 1'b0, "pre_rst_hi");
        start = 1'b1; md_op = 3'd1; a = 32'h0000_0003; b = 32'h0000_0004;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.hi", hi, 32'd0);
        chk("midrst.lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < MC + 3; k++) begin
            @(negedge clk);
            chk($sformatf("postrst.busy%0d", k), 32'(busy), 32'd0);
        end
        chk("postrst.hi", hi, 32'd0);
        chk("postrst.lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
